// File: rtl/parking_gate_sensor_if.sv
// Sensor inputs and passage outputs of the parking gate front end.
// The bench drives the master side; the gate sensor block is the slave.
interface parking_gate_sensor_if;
   logic a;
   logic b;
   logic enter;
   logic exit;
   logic busy;
   logic err;

   modport master (
      output a,
      output b,
      input  enter,
      input  exit,
      input  busy,
      input  err
   );

   modport slave (
      input  a,
      input  b,
      output enter,
      output exit,
      output busy,
      output err
   );
endinterface

// File: rtl/parking_gate_sensor.sv
// Parking gate front end: synchronizes and debounces the two photo-sensors, then tracks
// the passage direction and emits one enter/exit pulse per complete, legal passage.
module parking_gate_sensor #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 4,
   parameter int unsigned CNT_W       = 3
) (
   input logic                   clk,
   input logic                   rst_n,
   parking_gate_sensor_if.slave  gate_if
);

   typedef enum logic [2:0] {
      StIdle, StE1, StE2, StE3, StX1, StX2, StX3, StErr
   } state_e;

   // Bit 1 carries sensor a (outer beam), bit 0 sensor b (inner beam).
   logic [1:0]                  raw;
   logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]                  synced;
   logic [1:0]                  filt_q, filt_d;
   logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;

   state_e state_q, state_d;
   logic   enter_q, enter_d;
   logic   exit_q, exit_d;

   assign raw = {gate_if.a, gate_if.b};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
         synced[i] = sync_q[i][SYNC_STAGES-1];
         filt_d[i] = filt_q[i];
         cnt_d[i]  = '0;
         if (synced[i] != filt_q[i]) begin
            if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
               filt_d[i] = synced[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // The FSM looks at the filtered value being loaded this edge, so it moves on the same
   // edge the filter settles and the pulse lands SYNC_STAGES+DEBOUNCE-1 edges after sampling.
   always_comb begin
      state_d = state_q;
      enter_d = 1'b0;
      exit_d  = 1'b0;
      case (state_q)
         StIdle: begin
            case (filt_d)
               2'b10:   state_d = StE1;
               2'b01:   state_d = StX1;
               2'b11:   state_d = StErr;
               default: ;
            endcase
         end
         StE1: begin
            case (filt_d)
               2'b11:   state_d = StE2;
               2'b00:   state_d = StIdle;
               2'b01:   state_d = StErr;
               default: ;
            endcase
         end
         StE2: begin
            case (filt_d)
               2'b01:   state_d = StE3;
               2'b10:   state_d = StE1;
               2'b00:   state_d = StErr;
               default: ;
            endcase
         end
         StE3: begin
            case (filt_d)
               2'b00: begin
                  state_d = StIdle;
                  enter_d = 1'b1;
               end
               2'b11:   state_d = StE2;
               2'b10:   state_d = StErr;
               default: ;
            endcase
         end
         StX1: begin
            case (filt_d)
               2'b11:   state_d = StX2;
               2'b00:   state_d = StIdle;
               2'b10:   state_d = StErr;
               default: ;
            endcase
         end
         StX2: begin
            case (filt_d)
               2'b10:   state_d = StX3;
               2'b01:   state_d = StX1;
               2'b00:   state_d = StErr;
               default: ;
            endcase
         end
         StX3: begin
            case (filt_d)
               2'b00: begin
                  state_d = StIdle;
                  exit_d  = 1'b1;
               end
               2'b11:   state_d = StX2;
               2'b01:   state_d = StErr;
               default: ;
            endcase
         end
         StErr: begin
            if (filt_d == 2'b00) state_d = StIdle;
         end
         default: state_d = StErr;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         filt_q  <= '0;
         cnt_q   <= '0;
         state_q <= StIdle;
         enter_q <= 1'b0;
         exit_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         enter_q <= enter_d;
         exit_q  <= exit_d;
      end
   end

   assign gate_if.enter = enter_q;
   assign gate_if.exit  = exit_q;
   assign gate_if.busy  = (state_q != StIdle);
   assign gate_if.err   = (state_q == StErr);

endmodule
